md_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit; next generation of the combinational ALU.

---
 rtl/md_unit.sv | 135 +++++++++++++
 tb/tb_md_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are computed from operands latched at start and committed after a fixed latency.
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [3:0]       op_reg, op_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;

    // Result datapath, fed only by the latched operands
    logic               is_div, is_signed, div_zero;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        is_div    = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
        is_signed = (op_reg == OP_MULT) || (op_reg == OP_DIV);
        div_zero  = (b_reg == '0);

        a_ext = is_signed ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
        b_ext = is_signed ? {{WIDTH{b_reg[WIDTH-1]}}, b_reg} : {{WIDTH{1'b0}}, b_reg};
        prod  = a_ext * b_ext;

        // Signed division on magnitudes: MIN / -1 naturally yields MIN with remainder 0
        a_neg = is_signed & a_reg[WIDTH-1];
        b_neg = is_signed & b_reg[WIDTH-1];
        a_mag = a_neg ? -a_reg : a_reg;
        b_mag = b_neg ? -b_reg : b_reg;
        q_mag = div_zero ? '0 : a_mag / b_mag;
        r_mag = div_zero ? '0 : a_mag % b_mag;
        quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;

        if (is_div) begin
            res_lo = div_zero ? '1 : quot;
            res_hi = div_zero ? a_reg : rem;
        end else begin
            res_lo = prod[WIDTH-1:0];
            res_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_next = BUSY;
                            op_next    = md_op;
                            a_next     = A;
                            b_next     = B;
                            cnt_next   = (md_op == OP_DIV || md_op == OP_DIVU) ?
                                         CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        end
                        OP_MTHI: hi_next = A;
                        OP_MTLO: lo_next = A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // Any start while busy is dropped; the hazard unit is expected to stall
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = IDLE;
                    hi_next    = res_hi;
                    lo_next    = res_lo;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign busy = (state_reg == BUSY);
    assign hi   = hi_reg;
    assign lo   = lo_reg;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized operations
// compared against an arithmetic reference model of HI/LO.
module tb_md_unit;
    localparam int W    = 32;
    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   md_op;
    logic [W-1:0] A, B;
    logic         busy;
    logic [W-1:0] hi, lo;

    int total  = 0;
    int passed = 0;
    logic [W-1:0] hi_m, lo_m;

    md_unit #(.WIDTH(W), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Reference: plain 64-bit and int arithmetic following the HI/LO rules
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output int n);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        eh = hi_m;
        el = lo_m;
        n  = 0;
        case (op)
            4'd1: begin
                sa = a; sb = b;
                sp = longint'(sa) * longint'(sb);
                eh = sp[63:32]; el = sp[31:0]; n = MULN;
            end
            4'd2: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                eh = up[63:32]; el = up[31:0]; n = MULN;
            end
            4'd3: begin
                n = DIVN;
                if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = a; eh = 0; end
                else begin sa = a; sb = b; el = sa / sb; eh = sa % sb; end
            end
            4'd4: begin
                n = DIVN;
                if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
                else begin el = a / b; eh = a % b; end
            end
            default: ;
        endcase
    endfunction

    // mode 0: quiet, 1: random operand/start noise while busy, 2: MTHI 0x1234 every busy cycle
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int mode);
        int n, cycles;
        logic [31:0] eh, el;
        logic held;
        model(op, a, b, eh, el, n);
        @(negedge clk);
        start = 1'b1; md_op = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; md_op = 4'd0;
        check("busy_rise", {31'd0, busy}, 32'd1);
        cycles = 0;
        held   = 1'b1;
        while (busy && cycles < 200) begin
            if (hi !== hi_m || lo !== lo_m) held = 1'b0;
            if (mode == 1) begin
                A = $urandom; B = $urandom;
                start = 1'($urandom_range(0, 1));
                md_op = 4'($urandom_range(1, 6));
            end else if (mode == 2) begin
                A = 32'h1234; start = 1'b1; md_op = 4'd5;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0; md_op = 4'd0;
        check("hold_while_busy", {31'd0, held}, 32'd1);
        check("busy_cycles", 32'(cycles), 32'(n));
        check("hi_result", hi, eh);
        check("lo_result", lo, el);
        hi_m = eh; lo_m = el;
        $display("op=%0d A=%08h B=%08h mode=%0d cycles=%0d hi=%08h lo=%08h",
                 op, a, b, mode, cycles, hi, lo);
    endtask

    task automatic run_mt(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; md_op = op; A = a;
        @(posedge clk); #1;
        start = 1'b0; md_op = 4'd0;
        if (op == 4'd5) hi_m = a; else lo_m = a;
        check("mt_busy", {31'd0, busy}, 32'd0);
        check("mt_hi", hi, hi_m);
        check("mt_lo", lo, lo_m);
        $display("op=%0d A=%08h hi=%08h lo=%08h", op, a, hi, lo);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b0; start = 1'b0; md_op = 4'd0; A = '0; B = '0;
        hi_m = '0; lo_m = '0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk); reset = 1'b1;

        // Reset in the middle of a MULT
        run_mt(4'd5, 32'hAAAA_5555);
        run_mt(4'd6, 32'h5555_AAAA);
        @(negedge clk); start = 1'b1; md_op = 4'd1; A = 32'd7; B = 32'd9;
        @(posedge clk); #1; start = 1'b0; md_op = 4'd0;
        repeat (2) @(posedge clk);
        #3; reset = 1'b0; #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        hi_m = '0; lo_m = '0;
        @(negedge clk); reset = 1'b1;
        run_md(4'd2, 32'd3, 32'd4, 0);
        check("multu_3x4_lo", lo, 32'd12);

        // Directed arithmetic cases
        run_md(4'd1, 32'hFFFF_FFFE, 32'd3, 0);
        check("mult_hi_lit", hi, 32'hFFFF_FFFF);
        check("mult_lo_lit", lo, 32'hFFFF_FFFA);
        run_md(4'd2, 32'hFFFF_FFFE, 32'd3, 0);
        check("multu_hi_lit", hi, 32'h0000_0002);
        check("multu_lo_lit", lo, 32'hFFFF_FFFA);
        run_md(4'd3, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_lo_lit", lo, 32'hFFFF_FFFD);
        check("div_hi_lit", hi, 32'hFFFF_FFFF);
        run_md(4'd4, 32'd7, 32'd2, 0);
        check("divu_lo_lit", lo, 32'd3);
        check("divu_hi_lit", hi, 32'd1);
        run_md(4'd4, 32'd5, 32'd0, 0);
        check("divu0_lo_lit", lo, 32'hFFFF_FFFF);
        check("divu0_hi_lit", hi, 32'd5);
        run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("divovf_lo_lit", lo, 32'h8000_0000);
        check("divovf_hi_lit", hi, 32'd0);
        run_md(4'd3, 32'd100, 32'hFFFF_FFF9, 0);

        // MTHI ignored while busy, then accepted when idle
        run_md(4'd2, 32'h0001_0001, 32'h0000_0100, 2);
        run_mt(4'd5, 32'h1234);
        check("mthi_lit", hi, 32'h1234);

        // Operand changes and stray starts during busy, then back-to-back starts
        run_md(4'd1, 32'h0000_7FFF, 32'hFFFF_0003, 1);
        run_md(4'd4, 32'hDEAD_BEEF, 32'h0000_1235, 1);
        run_md(4'd3, 32'h8765_4321, 32'h0000_0011, 0);

        for (int i = 0; i < 30; i++) begin
            rop = 4'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9)) - 32'd4;
            if (rop <= 4'd4) run_md(rop, ra, rb, int'($urandom_range(0, 1)));
            else run_mt(rop, ra);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
